// File: rtl/alu8_rr_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu8_rr_sched
// Shares one combinational 8-bit ALU among NREQ requesters with round-robin
// arbitration. One operation is in flight at a time. Each operation passes
// through IDLE (grant), EXEC (ALU evaluates the registered operands) and
// RESP (result held until the consumer accepts it).
//
// Parameters
//   NREQ       number of requesters (2..8)
//   IDW        width of rsp_id, $clog2(NREQ) with a minimum of 1
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   req_valid/req_ready            per-requester handshake, req_ready one-hot
//   req_a/req_b/req_op/req_sh      packed per-requester operands (slice i)
//   alu_a/alu_b/alu_op/alu_sh      registered operands towards the ALU
//   alu_y/alu_flags                ALU result and {Z,C,N,V}
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_y/rsp_flags         served requester index and captured result
//   ops_done                       completed handshakes, saturating
//                                  (only when ALU8_PERF_CNT_EN is defined)
// -----------------------------------------------------------------------------
module alu8_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [3*NREQ-1:0] req_sh,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_op,
    output logic [2:0]        alu_sh,
    input  logic [7:0]        alu_y,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_y,
    output logic [3:0]        rsp_flags
`ifdef ALU8_PERF_CNT_EN
    ,
    output logic [15:0]       ops_done
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   last_grant_r;
    logic             grant_found_s;
    logic [IDW-1:0]   grant_idx_s;

    // Round-robin search: first valid requester after last_grant_r, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {IDW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found_s && req_valid[(int'(last_grant_r) + k) % NREQ]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IDW'((int'(last_grant_r) + k) % NREQ);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot accept, only in IDLE; gated by rst_n so it reads zero while
    // reset is held even if requesters keep req_valid high.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (rst_n && (state_r == IDLE) && grant_found_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Scheduler FSM: grant and latch operands, capture ALU result, hold response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= IDW'(NREQ - 1);
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_op       <= 4'h0;
            alu_sh       <= 3'd0;
            rsp_valid    <= 1'b0;
            rsp_id       <= {IDW{1'b0}};
            rsp_y        <= 8'h00;
            rsp_flags    <= 4'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        alu_a   <= req_a[32'(grant_idx_s)*8 +: 8];
                        alu_b   <= req_b[32'(grant_idx_s)*8 +: 8];
                        alu_op  <= req_op[32'(grant_idx_s)*4 +: 4];
                        alu_sh  <= req_sh[32'(grant_idx_s)*3 +: 3];
                        rsp_id  <= grant_idx_s;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_flags <= alu_flags;
                    rsp_valid <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    // Rotation pointer advances only once the result is taken.
                    if (rsp_ready) begin
                        last_grant_r <= rsp_id;
                        rsp_valid    <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU8_PERF_CNT_EN
    logic [15:0] ops_done_r;

    // Saturating count of accepted responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done_r <= 16'h0000;
        end else if (rsp_valid && rsp_ready && (ops_done_r != 16'hFFFF)) begin
            ops_done_r <= ops_done_r + 16'd1;
        end else begin
            ops_done_r <= ops_done_r;
        end
    end

    assign ops_done = ops_done_r;
`endif

endmodule

// File: tb/tb_alu8_rr_sched.sv
`timescale 1ns/1ps
// Self-checking bench for alu8_rr_sched with a behavioural 8-bit ALU on the
// alu_* ports (op 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, else pass A).
module tb_alu8_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [4*NREQ-1:0] req_op;
    logic [3*NREQ-1:0] req_sh;
    logic [7:0]        alu_a, alu_b, alu_y;
    logic [3:0]        alu_op, alu_flags;
    logic [2:0]        alu_sh;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_y;
    logic [3:0]        rsp_flags;
`ifdef ALU8_PERF_CNT_EN
    logic [15:0]       ops_done;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    alu8_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_sh    (req_sh),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_sh    (alu_sh),
        .alu_y     (alu_y),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_flags (rsp_flags)
`ifdef ALU8_PERF_CNT_EN
        ,
        .ops_done  (ops_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU, flags {Z,C,N,V}; C is carry for add, borrow for sub.
    logic [8:0] alu_t;
    logic       alu_c, alu_v;
    always_comb begin
        alu_t = 9'h000;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            4'd0: begin
                alu_t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = alu_t[8];
                alu_v = (alu_a[7] == alu_b[7]) && (alu_t[7] != alu_a[7]);
            end
            4'd1: begin
                alu_t = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c = alu_t[8];
                alu_v = (alu_a[7] != alu_b[7]) && (alu_t[7] != alu_a[7]);
            end
            4'd2: alu_t = {1'b0, alu_a & alu_b};
            4'd3: alu_t = {1'b0, alu_a | alu_b};
            4'd4: alu_t = {1'b0, alu_a ^ alu_b};
            4'd5: alu_t = {1'b0, alu_a << alu_sh};
            4'd6: alu_t = {1'b0, alu_a >> alu_sh};
            default: alu_t = {1'b0, alu_a};
        endcase
        alu_y     = alu_t[7:0];
        alu_flags = {(alu_t[7:0] == 8'h00), alu_c, alu_t[7], alu_v};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic [2:0] sh);
        req_a[8*id +: 8]  = a;
        req_b[8*id +: 8]  = b;
        req_op[4*id +: 4] = op;
        req_sh[3*id +: 3] = sh;
    endtask

    // Enter/leave reset; returns #1 after a rising edge with the DUT in IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_alu_a", 32'(alu_a), 32'h0);
        rst_n = 1'b1;
    endtask

    // Bounded wait for rsp_valid; timeout counts as a failed comparison.
    task automatic wait_rsp(input string nm, output int at_cyc);
        logic found;
        found  = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                found  = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        chk({nm, "_rsp_timeout"}, 32'(found), 32'h1);
    endtask

    // Single isolated operation with fixed-latency checks; starts and ends in IDLE.
    task automatic do_op(input string nm, input int id, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] op, input logic [2:0] sh,
                         input logic [7:0] ey, input logic [3:0] ef);
        logic [NREQ-1:0] oh;
        oh        = 4'b0001 << id;
        set_req(id, a, b, op, sh);
        req_valid = oh;
        rsp_ready = 1'b1;
        #1;
        chk({nm, "_req_ready"}, 32'(req_ready), 32'(oh));
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        chk({nm, "_exec_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({nm, "_alu_a"}, 32'(alu_a), 32'(a));
        @(posedge clk);
        #1;
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        chk({nm, "_rsp_id"}, 32'(rsp_id), 32'(id));
        chk({nm, "_rsp_y"}, 32'(rsp_y), 32'(ey));
        chk({nm, "_rsp_flags"}, 32'(rsp_flags), 32'(ef));
        @(posedge clk);
        #1;
        chk({nm, "_rsp_drop"}, 32'(rsp_valid), 32'h0);
    endtask

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [2:0] sh;
        logic [7:0] y;
        logic [3:0] f;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int c, prev, bad;
        vecs[0] = '{0, 8'h14, 8'h22, 4'd0, 3'd0, 8'h36, 4'b0000};
        vecs[1] = '{1, 8'hFF, 8'h01, 4'd0, 3'd0, 8'h00, 4'b1100};
        vecs[2] = '{2, 8'h7F, 8'h01, 4'd0, 3'd0, 8'h80, 4'b0011};
        vecs[3] = '{3, 8'h10, 8'h01, 4'd1, 3'd0, 8'h0F, 4'b0000};
        vecs[4] = '{0, 8'h01, 8'h02, 4'd1, 3'd0, 8'hFF, 4'b0110};
        vecs[5] = '{1, 8'hF0, 8'h3C, 4'd2, 3'd0, 8'h30, 4'b0000};
        vecs[6] = '{2, 8'h81, 8'h00, 4'd5, 3'd1, 8'h02, 4'b0000};
        vecs[7] = '{3, 8'h81, 8'h00, 4'd6, 3'd3, 8'h10, 4'b0000};
        vecs[8] = '{0, 8'hAA, 8'hAA, 4'd4, 3'd0, 8'h00, 4'b1000};

        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_a     = 32'h0;
        req_b     = 32'h0;
        req_op    = 16'h0;
        req_sh    = 12'h0;
        rsp_ready = 1'b0;
        do_reset();

        // Single ops (vector 0 is the first op after reset).
        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b,
                  vecs[i].op, vecs[i].sh, vecs[i].y, vecs[i].f);
        end

        // All requesters valid: grant order 0,1,2,3,0, three cycles apart.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h01 + 8'(16*i), 8'h01, 4'd0, 3'd0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        prev = -1;
        for (int n = 0; n < 5; n++) begin
            wait_rsp($sformatf("rr%0d", n), c);
            chk($sformatf("rr%0d_id", n), 32'(rsp_id), 32'(n % 4));
            chk($sformatf("rr%0d_y", n), 32'(rsp_y), 32'(8'h02 + 8'(16*(n % 4))));
            if (n > 0) chk($sformatf("rr%0d_spacing", n), 32'(c - prev), 32'd3);
            prev = c;
        end
        req_valid = 4'b0000;
        @(posedge clk);
        #1;

        // Backpressure: response held for 5 cycles, then completes in 1.
        set_req(2, 8'h10, 8'h01, 4'd1, 3'd0);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        wait_rsp("bp", c);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || rsp_y !== 8'h0F || req_ready !== 4'b0000) bad++;
        end
        chk("bp_hold_bad_cycles", 32'(bad), 32'd0);
        chk("bp_rsp_y", 32'(rsp_y), 32'h0F);
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("bp_complete", 32'(rsp_valid), 32'h0);

        // Rotation skip: last_grant=1, req_valid=1001 -> 3 then 0.
        do_op("skip_pre", 1, 8'h05, 8'h06, 4'd0, 3'd0, 8'h0B, 4'b0000);
        set_req(3, 8'h33, 8'h00, 4'd0, 3'd0);
        set_req(0, 8'h44, 8'h00, 4'd0, 3'd0);
        req_valid = 4'b1001;
        #1;
        chk("skip_ready3", 32'(req_ready), 32'b1000);
        wait_rsp("skip3", c);
        chk("skip3_id", 32'(rsp_id), 32'd3);
        chk("skip3_y", 32'(rsp_y), 32'h33);
        @(posedge clk);
        #1;
        chk("skip_ready0", 32'(req_ready), 32'b0001);
        wait_rsp("skip0", c);
        chk("skip0_id", 32'(rsp_id), 32'd0);
        chk("skip0_y", 32'(rsp_y), 32'h44);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;

        // Reset during EXEC: outputs clear at once, no response, requester 0 next.
        set_req(1, 8'h14, 8'h22, 4'd3, 3'd5);
        req_valid = 4'b0010;
        @(posedge clk);
        #2;
        chk("rst_exec_alu_a", 32'(alu_a), 32'h14);
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_y", 32'(rsp_y), 32'h0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'h0);
        chk("rst_alu_ops", 32'({alu_a, alu_b, alu_op, alu_sh}), 32'h0);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) bad++;
        end
        chk("rst_no_rsp", 32'(bad), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst_next_grant", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;

`ifdef ALU8_PERF_CNT_EN
        // Performance counter: counts handshakes and saturates.
        do_reset();
        chk("perf_reset", 32'(ops_done), 32'h0);
        for (int i = 0; i < 3; i++) do_op($sformatf("perf%0d", i), i, 8'h01, 8'h01, 4'd0, 3'd0, 8'h02, 4'b0000);
        chk("perf_three", 32'(ops_done), 32'd3);
        force dut.ops_done_r = 16'hFFFF;
        #1;
        release dut.ops_done_r;
        do_op("perf_sat_op", 3, 8'h01, 8'h01, 4'd0, 3'd0, 8'h02, 4'b0000);
        chk("perf_saturate", 32'(ops_done), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
